// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU request path and the writeback stage.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2
  } lsu_state_e;

  // Size codes, packed as {signed,h,b}.
  localparam logic [2:0] SZ_W  = 3'b000;
  localparam logic [2:0] SZ_SH = 3'b110;
  localparam logic [2:0] SZ_SB = 3'b101;
  localparam logic [2:0] SZ_UH = 3'b010;
  localparam logic [2:0] SZ_UB = 3'b001;

  // Bit positions inside the {signed,h,b} field handed to writeback.
  localparam int WB_SEXT = 2;
  localparam int WB_H    = 1;
  localparam int WB_B    = 0;

endpackage

// File: rtl/lsu_store_align.sv
// Combinational decode of a memory op: byte enables, lane-replicated store
// data, alignment check and size-code legality.
module lsu_store_align
  import lsu_pkg::*;
(
  input  logic        ls,
  input  logic [2:0]  sext_hb,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misaligned,
  output logic        illegal
);

  logic code_bad_s;

  // Decode size code into lanes, replicated data and alignment status.
  always_comb begin
    be         = 4'b0000;
    wdata_rep  = 32'h0000_0000;
    misaligned = 1'b0;
    code_bad_s = 1'b0;
    case (sext_hb)
      SZ_W: begin
        be         = 4'b1111;
        wdata_rep  = wdata;
        misaligned = (addr_lo != 2'b00);
      end
      SZ_SH, SZ_UH: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      SZ_SB, SZ_UB: begin
        be         = 4'b0001 << addr_lo;
        wdata_rep  = {4{wdata[7:0]}};
        misaligned = 1'b0;
      end
      default: begin
        code_bad_s = 1'b1;
      end
    endcase
    // A signed store has no meaning, so it is rejected like a bad code.
    illegal = code_bad_s | (~ls & sext_hb[WB_SEXT]);
  end

endmodule

// File: rtl/lsu_mem_req.sv
// Data-memory request side of the LSU: accepts one op at a time from execute,
// issues the bus request, waits for load data (with timeout) and reports
// completion, exceptions and bus errors as single-cycle pulses.
module lsu_mem_req
  import lsu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ADDR_LEN = 32,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic                ex_ls,
  input  logic                ex_signed,
  input  logic                ex_h,
  input  logic                ex_b,
  input  logic [ADDR_LEN-1:0] ex_addr,
  input  logic [WIDTH-1:0]    ex_wdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_LEN-1:0] mem_req_addr,
  output logic [3:0]          mem_req_be,
  output logic [WIDTH-1:0]    mem_req_wdata,
  input  logic                mem_resp_valid,
  input  logic [WIDTH-1:0]    mem_resp_data,
  output logic                wb_valid,
  output logic                wb_ls,
  output logic [WIDTH-1:0]    wb_rdata,
  output logic [1:0]          wb_addr_lo,
  output logic [2:0]          wb_sext_hb,
  output logic                lsu_exc,
  output logic                bus_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  logic [3:0]       be_s;
  logic [WIDTH-1:0] wrep_s;
  logic             misal_s;
  logic             illegal_s;

  lsu_store_align u_align (
    .ls         (ex_ls),
    .sext_hb    ({ex_signed, ex_h, ex_b}),
    .addr_lo    (ex_addr[1:0]),
    .wdata      (ex_wdata),
    .be         (be_s),
    .wdata_rep  (wrep_s),
    .misaligned (misal_s),
    .illegal    (illegal_s)
  );

  lsu_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                op_ls_q, op_ls_d;
  logic [2:0]          op_sext_q, op_sext_d;
  logic [1:0]          op_lo_q, op_lo_d;
  logic                ex_ready_q, ex_ready_d;
  logic                req_valid_q, req_valid_d;
  logic                req_we_q, req_we_d;
  logic [ADDR_LEN-1:0] req_addr_q, req_addr_d;
  logic [3:0]          req_be_q, req_be_d;
  logic [WIDTH-1:0]    req_wdata_q, req_wdata_d;
  logic                wb_valid_q, wb_valid_d;
  logic                wb_ls_q, wb_ls_d;
  logic [WIDTH-1:0]    wb_rdata_q, wb_rdata_d;
  logic [1:0]          wb_lo_q, wb_lo_d;
  logic [2:0]          wb_sext_q, wb_sext_d;
  logic                lsu_exc_q, lsu_exc_d;
  logic                bus_err_q, bus_err_d;

  // Next-state and next-output computation for the request/response FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_ls_d     = op_ls_q;
    op_sext_d   = op_sext_q;
    op_lo_d     = op_lo_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_be_d    = req_be_q;
    req_wdata_d = req_wdata_q;
    wb_ls_d     = wb_ls_q;
    wb_rdata_d  = wb_rdata_q;
    wb_lo_d     = wb_lo_q;
    wb_sext_d   = wb_sext_q;
    wb_valid_d  = 1'b0;
    lsu_exc_d   = 1'b0;
    bus_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (illegal_s | misal_s) begin
            lsu_exc_d = 1'b1;
          end else begin
            state_d     = REQ;
            op_ls_d     = ex_ls;
            op_sext_d   = {ex_signed, ex_h, ex_b};
            op_lo_d     = ex_addr[1:0];
            req_we_d    = ~ex_ls;
            req_addr_d  = {ex_addr[ADDR_LEN-1:2], 2'b00};
            req_be_d    = be_s;
            req_wdata_d = wrep_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          if (op_ls_q) begin
            state_d = WAIT_RESP;
            cnt_d   = {CW{1'b0}};
          end else begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_ls_d    = 1'b0;
            wb_lo_d    = op_lo_q;
            wb_sext_d  = op_sext_q;
          end
        end else begin
          state_d = REQ;
        end
      end
      WAIT_RESP: begin
        // Data arriving on the last allowed cycle still wins over the timeout.
        if (mem_resp_valid) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_ls_d    = 1'b1;
          wb_rdata_d = mem_resp_data;
          wb_lo_d    = op_lo_q;
          wb_sext_d  = op_sext_q;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = IDLE;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ex_ready_d  = (state_d == IDLE);
    req_valid_d = (state_d == REQ);
  end

  // State, captured op fields and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      op_ls_q     <= 1'b0;
      op_sext_q   <= 3'b000;
      op_lo_q     <= 2'b00;
      ex_ready_q  <= 1'b1;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= {ADDR_LEN{1'b0}};
      req_be_q    <= 4'b0000;
      req_wdata_q <= {WIDTH{1'b0}};
      wb_valid_q  <= 1'b0;
      wb_ls_q     <= 1'b0;
      wb_rdata_q  <= {WIDTH{1'b0}};
      wb_lo_q     <= 2'b00;
      wb_sext_q   <= 3'b000;
      lsu_exc_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_ls_q     <= op_ls_d;
      op_sext_q   <= op_sext_d;
      op_lo_q     <= op_lo_d;
      ex_ready_q  <= ex_ready_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_be_q    <= req_be_d;
      req_wdata_q <= req_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_ls_q     <= wb_ls_d;
      wb_rdata_q  <= wb_rdata_d;
      wb_lo_q     <= wb_lo_d;
      wb_sext_q   <= wb_sext_d;
      lsu_exc_q   <= lsu_exc_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign ex_ready      = ex_ready_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_we    = req_we_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_be    = req_be_q;
  assign mem_req_wdata = req_wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_ls         = wb_ls_q;
  assign wb_rdata      = wb_rdata_q;
  assign wb_addr_lo    = wb_lo_q;
  assign wb_sext_hb    = wb_sext_q;
  assign lsu_exc       = lsu_exc_q;
  assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_lsu_mem_req.sv
// Self-checking bench for lsu_mem_req: directed vector table, hand-written
// multi-cycle sequences and randomized ops against a behavioural model.
module tb_lsu_mem_req;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_ls, ex_signed, ex_h, ex_b;
  logic [31:0] ex_addr, ex_wdata;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        wb_valid, wb_ls;
  logic [31:0] wb_rdata;
  logic [1:0]  wb_addr_lo;
  logic [2:0]  wb_sext_hb;
  logic        lsu_exc, bus_err;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_load = 32'h0;

  lsu_mem_req #(.WIDTH(32), .ADDR_LEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ls(ex_ls), .ex_signed(ex_signed),
    .ex_h(ex_h), .ex_b(ex_b), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .wb_valid(wb_valid), .wb_ls(wb_ls), .wb_rdata(wb_rdata), .wb_addr_lo(wb_addr_lo),
    .wb_sext_hb(wb_sext_hb), .lsu_exc(lsu_exc), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ls, sg, h, b;
    logic [31:0] addr, wdata;
    logic        exc;
    logic [3:0]  be;
    logic [31:0] wrep;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: access size in bytes, natural alignment, lane fill.
  function automatic void model(input logic ls, sg, h, b, input logic [31:0] addr, wdata,
                                output logic exc, output logic [3:0] be, output logic [31:0] wrep);
    int n;
    int lo;
    logic [2:0] code;
    code = {sg, h, b};
    n = 0;
    if (code == 3'b000) n = 4;
    else if (code == 3'b010 || code == 3'b110) n = 2;
    else if (code == 3'b001 || code == 3'b101) n = 1;
    lo = int'(addr[1:0]);
    exc = (n == 0) || (!ls && sg) || ((lo % ((n == 0) ? 1 : n)) != 0);
    be = 4'b0000;
    wrep = 32'h0;
    if (!exc) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= lo && i < lo + n) be[i] = 1'b1;
        wrep[8*i +: 8] = wdata[8*(i % n) +: 8];
      end
    end
  endfunction

  task automatic run_op(input logic ls, sg, h, b, input logic [31:0] addr, wdata,
                        input int rdy_dly, input int rsp_dly, input logic [31:0] rdata,
                        input logic to, input logic junk);
    logic exc;
    logic [3:0] be;
    logic [31:0] wrep;
    int got;
    model(ls, sg, h, b, addr, wdata, exc, be, wrep);
    chk("ex_ready_idle", 32'(ex_ready), 32'd1);
    ex_valid = 1'b1; ex_ls = ls; ex_signed = sg; ex_h = h; ex_b = b;
    ex_addr = addr; ex_wdata = wdata;
    step();
    ex_valid = junk & !exc;
    ex_addr = $urandom; ex_wdata = $urandom;
    {ex_ls, ex_signed, ex_h, ex_b} = 4'($urandom);
    chk("lsu_exc", 32'(lsu_exc), 32'(exc));
    chk("wb_valid_accept", 32'(wb_valid), 32'd0);
    chk("req_valid_accept", 32'(mem_req_valid), 32'(!exc));
    chk("ex_ready_accept", 32'(ex_ready), 32'(exc));
    if (exc) begin
      step();
      chk("lsu_exc_pulse", 32'(lsu_exc), 32'd0);
      chk("req_valid_after_exc", 32'(mem_req_valid), 32'd0);
      return;
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      chk("req_valid_hold", 32'(mem_req_valid), 32'd1);
      chk("ex_ready_busy", 32'(ex_ready), 32'd0);
      chk("req_we", 32'(mem_req_we), 32'(!ls));
      chk("req_addr", mem_req_addr, addr & 32'hFFFF_FFFC);
      chk("req_be", 32'(mem_req_be), 32'(be));
      if (!ls) chk("req_wdata", mem_req_wdata, wrep);
      if (i == rdy_dly) begin
        mem_req_ready = 1'b1;
        mem_resp_valid = junk;
        mem_resp_data = ~rdata;
      end
      step();
    end
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    chk("req_valid_drop", 32'(mem_req_valid), 32'd0);
    if (!ls) begin
      ex_valid = 1'b0;
      chk("st_wb_valid", 32'(wb_valid), 32'd1);
      chk("st_wb_ls", 32'(wb_ls), 32'd0);
      chk("st_wb_addr_lo", 32'(wb_addr_lo), 32'(addr[1:0]));
      chk("st_wb_sext_hb", 32'(wb_sext_hb), 32'({sg, h, b}));
      chk("wb_rdata_held", wb_rdata, last_load);
      chk("st_ex_ready", 32'(ex_ready), 32'd1);
      step();
      chk("st_wb_pulse", 32'(wb_valid), 32'd0);
      return;
    end
    chk("ld_wait_ready", 32'(ex_ready), 32'd0);
    chk("ld_wait_wb", 32'(wb_valid), 32'd0);
    if (to) begin
      got = 0;
      for (int k = 1; k <= TO + 4; k++) begin
        step();
        chk("to_no_wb", 32'(wb_valid), 32'd0);
        if (bus_err) begin
          got = k;
          break;
        end
      end
      ex_valid = 1'b0;
      chk("timeout_cycles", 32'(got), 32'(TO));
      chk("to_ex_ready", 32'(ex_ready), 32'd1);
      mem_resp_valid = 1'b1;
      mem_resp_data = rdata;
      step();
      mem_resp_valid = 1'b0;
      chk("late_resp_no_wb", 32'(wb_valid), 32'd0);
      chk("bus_err_pulse", 32'(bus_err), 32'd0);
      step();
      chk("late_resp_no_wb2", 32'(wb_valid), 32'd0);
    end else begin
      for (int i = 0; i < rsp_dly; i++) begin
        step();
        chk("ld_wait_no_wb", 32'(wb_valid), 32'd0);
        chk("ld_wait_no_err", 32'(bus_err), 32'd0);
      end
      mem_resp_valid = 1'b1;
      mem_resp_data = rdata;
      step();
      mem_resp_valid = 1'b0;
      ex_valid = 1'b0;
      last_load = rdata;
      chk("ld_wb_valid", 32'(wb_valid), 32'd1);
      chk("ld_wb_ls", 32'(wb_ls), 32'd1);
      chk("ld_wb_rdata", wb_rdata, rdata);
      chk("ld_wb_addr_lo", 32'(wb_addr_lo), 32'(addr[1:0]));
      chk("ld_wb_sext_hb", 32'(wb_sext_hb), 32'({sg, h, b}));
      chk("ld_ex_ready", 32'(ex_ready), 32'd1);
      step();
      chk("ld_wb_pulse", 32'(wb_valid), 32'd0);
      chk("ld_wb_rdata_hold", wb_rdata, rdata);
    end
  endtask

  initial begin
    vec_t vecs[12];
    logic [2:0] codes[8];
    logic [2:0] c;
    logic       lsr;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1003, 32'h0000_00AB, 1'b0, 4'b1000, 32'hABAB_ABAB};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_2002, 32'h5555_1234, 1'b0, 4'b1100, 32'h1234_1234};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_2001, 32'h0000_1234, 1'b1, 4'b0000, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3001, 32'h0, 1'b1, 4'b0000, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 1'b0, 4'b0001, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0042, 32'h0, 1'b0, 4'b1100, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 4'b0000, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h0, 1'b1, 4'b0000, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h0, 1'b1, 4'b0000, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 4'b0000, 32'h0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0045, 32'h0, 1'b0, 4'b0010, 32'h0};
    codes = '{3'b000, 3'b110, 3'b010, 3'b101, 3'b001, 3'b011, 3'b111, 3'b100};

    rst = 1'b1; ex_valid = 1'b0; ex_ls = 1'b0; ex_signed = 1'b0; ex_h = 1'b0; ex_b = 1'b0;
    ex_addr = 32'h0; ex_wdata = 32'h0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_resp_data = 32'h0;
    step(); step();
    rst = 1'b0;
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'h0);
    chk("rst_req_be", 32'(mem_req_be), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_rdata", wb_rdata, 32'h0);
    chk("rst_lsu_exc", 32'(lsu_exc), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);

    // Directed table: independent expectations cross-checked against the model-driven run.
    foreach (vecs[i]) begin
      logic e; logic [3:0] mbe; logic [31:0] mw;
      model(vecs[i].ls, vecs[i].sg, vecs[i].h, vecs[i].b, vecs[i].addr, vecs[i].wdata, e, mbe, mw);
      chk("tbl_model_exc", 32'(e), 32'(vecs[i].exc));
      chk("tbl_model_be", 32'(mbe), 32'(vecs[i].be));
      if (!vecs[i].ls && !vecs[i].exc) chk("tbl_model_wrep", mw, vecs[i].wrep);
      run_op(vecs[i].ls, vecs[i].sg, vecs[i].h, vecs[i].b, vecs[i].addr, vecs[i].wdata,
             0, 1, $urandom, 1'b0, 1'b0);
    end

    // Signed halfword load with data two cycles after the handshake.
    run_op(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_2002, 32'h0, 0, 1, 32'h8001_0000, 1'b0, 1'b1);
    // Store held off for five cycles by the memory.
    run_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_4000, 32'hCAFE_F00D, 5, 0, 32'h0, 1'b0, 1'b1);
    // Load with no response ends in a bus error; the late response is dropped.
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_5000, 32'h0, 1, 0, 32'h1357_9BDF, 1'b1, 1'b0);
    // Response on the very last allowed cycle still completes.
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_5004, 32'h0, 0, TO - 1, 32'h2468_ACE0, 1'b0, 1'b0);

    // Reset while waiting for load data.
    ex_valid = 1'b1; ex_ls = 1'b1; ex_signed = 1'b0; ex_h = 1'b0; ex_b = 1'b0; ex_addr = 32'h500;
    step();
    ex_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_load = 32'h0;
    chk("rstw_ex_ready", 32'(ex_ready), 32'd1);
    chk("rstw_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rstw_wb_valid", 32'(wb_valid), 32'd0);
    chk("rstw_bus_err", 32'(bus_err), 32'd0);
    chk("rstw_wb_rdata", wb_rdata, 32'h0);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h7777_7777;
    step();
    mem_resp_valid = 1'b0;
    chk("rstw_late_resp", 32'(wb_valid), 32'd0);
    step();
    chk("rstw_late_resp2", 32'(wb_valid), 32'd0);

    // Reset while a store request is pending.
    ex_valid = 1'b1; ex_ls = 1'b0; ex_addr = 32'h600; ex_wdata = 32'h1;
    step();
    ex_valid = 1'b0;
    chk("rstr_req_valid_before", 32'(mem_req_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstr_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rstr_ex_ready", 32'(ex_ready), 32'd1);
    step();
    chk("rstr_wb_valid", 32'(wb_valid), 32'd0);

    // Randomized ops against the model.
    for (int n = 0; n < 60; n++) begin
      c = codes[$urandom_range(0, 7)];
      lsr = 1'($urandom);
      run_op(lsr, c[2], c[1], c[0], $urandom, $urandom, $urandom_range(0, 3),
             $urandom_range(0, 4), $urandom, lsr && ($urandom_range(0, 7) == 0), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

endmodule
